// File: rtl/gcd_arb_pkg.sv
// Shared types and helpers for the GCD coprocessor arbiter.
package gcd_arb_pkg;

  localparam int unsigned STAT_W = 16;

  // Bit width needed to index n items, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 3) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo N.
module gcd_rr_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt_onehot,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  logic [IDW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    idx    = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDW'((32'(ptr) + 32'(k)) % N);
      if (req[idx]) begin
        gnt_id = idx;
        any    = 1'b1;
      end
    end
    gnt_onehot = any ? (N'(1) << gnt_id) : '0;
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one in-order GCD coprocessor between N requesters with round-robin issue and tag-based result steering.
// Optional per-requester issue/completion counters: define GCD_ARBITER_STATS_EN.
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int unsigned W         = 32,
  parameter int unsigned N         = 4,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_val,
  output logic [N-1:0]     req_rdy,
  input  logic [N*W-1:0]   req_bits_A,
  input  logic [N*W-1:0]   req_bits_B,
  output logic [N-1:0]     resp_val,
  input  logic [N-1:0]     resp_rdy,
  output logic [W-1:0]     resp_bits,
  output logic             cop_operands_val,
  input  logic             cop_operands_rdy,
  output logic [W-1:0]     cop_operands_bits_A,
  output logic [W-1:0]     cop_operands_bits_B,
  input  logic             cop_result_val,
  output logic             cop_result_rdy,
  input  logic [W-1:0]     cop_result_bits
`ifdef GCD_ARBITER_STATS_EN
  ,
  output logic [N*STAT_W-1:0] stat_issued,
  output logic [N*STAT_W-1:0] stat_completed
`endif
);

  localparam int unsigned IDW = clog2_min1(N);
  localparam int unsigned PW  = clog2_min1(TAG_DEPTH);
  localparam int unsigned CW  = clog2_min1(TAG_DEPTH + 1);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] tag_q [TAG_DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;

  logic [N-1:0]   gnt_onehot;
  logic [IDW-1:0] gnt_id;
  logic           gnt_any;
  logic           can_issue;
  logic           has_tag;
  logic [IDW-1:0] head_id;
  logic           push;
  logic           pop;

  gcd_rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_rr (
    .req        (req_val),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_id     (gnt_id),
    .any        (gnt_any)
  );

  // Issue side never looks at the result handshake, keeping the two paths independent.
  assign can_issue        = (count < CW'(TAG_DEPTH));
  assign cop_operands_val = can_issue & gnt_any;
  assign req_rdy          = gnt_onehot & {N{can_issue & cop_operands_rdy}};
  assign push             = cop_operands_val & cop_operands_rdy;

  always_comb begin
    cop_operands_bits_A = '0;
    cop_operands_bits_B = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_onehot[i]) begin
        cop_operands_bits_A = req_bits_A[i*W +: W];
        cop_operands_bits_B = req_bits_B[i*W +: W];
      end
    end
  end

  // Results complete in issue order, so the queue head names the owner.
  assign has_tag        = (count != '0);
  assign head_id        = tag_q[head];
  assign resp_val       = (cop_result_val & has_tag) ? (N'(1) << head_id) : '0;
  assign cop_result_rdy = has_tag & resp_rdy[head_id];
  assign resp_bits      = cop_result_bits;
  assign pop            = cop_result_val & cop_result_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        tail   <= (tail == PW'(TAG_DEPTH - 1)) ? '0 : tail + PW'(1);
        rr_ptr <= (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
      end
      if (pop) begin
        head <= (head == PW'(TAG_DEPTH - 1)) ? '0 : head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag storage needs no reset; entries are only read while count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail] <= gnt_id;
    end
  end

`ifdef GCD_ARBITER_STATS_EN
  for (genvar g = 0; g < N; g++) begin : g_stat
    logic [STAT_W-1:0] issued_q;
    logic [STAT_W-1:0] completed_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        issued_q    <= '0;
        completed_q <= '0;
      end else begin
        if (push && (gnt_id == IDW'(g)) && (issued_q != '1)) begin
          issued_q <= issued_q + STAT_W'(1);
        end
        if (pop && (head_id == IDW'(g)) && (completed_q != '1)) begin
          completed_q <= completed_q + STAT_W'(1);
        end
      end
    end

    assign stat_issued[g*STAT_W +: STAT_W]    = issued_q;
    assign stat_completed[g*STAT_W +: STAT_W] = completed_q;
  end
`endif

endmodule
